// File: rtl/accum_dump_dec.sv
// ============================================================================
// Module   : accum_dump_dec
// Purpose  : Integrate-and-dump decimator: sums DEC signed samples, scales the
//            sum by an arithmetic right shift and saturates it to DW bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_dump_dec #(
  parameter int DW    = 25,
  parameter int DEC   = 4,
  parameter int SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] data_in,
  input  logic                 clear,
  output logic signed [DW-1:0] data_out,
  output logic                 out_valid,
  output logic                 sat_flag
);

  localparam int CW = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int AW = DW + CW;

  localparam logic [CW-1:0]        CNT_LAST = CW'(DEC - 1);
  localparam logic signed [AW-1:0] SAT_MAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;

  logic signed [AW-1:0] w_sample;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_scaled;
  logic signed [DW-1:0] w_clamped;
  logic                 w_sat;

  // The accumulator is wide enough for DEC full-scale samples, so the sum
  // never wraps; only the scaled result needs clamping.
  always_comb begin
    w_sample = {{CW{data_in[DW-1]}}, data_in};
    w_sum    = acc_q + w_sample;
    w_scaled = w_sum >>> SHIFT;

    if (w_scaled > SAT_MAX) begin
      w_clamped = SAT_MAX[DW-1:0];
      w_sat     = 1'b1;
    end else if (w_scaled < SAT_MIN) begin
      w_clamped = SAT_MIN[DW-1:0];
      w_sat     = 1'b1;
    end else begin
      w_clamped = w_scaled[DW-1:0];
      w_sat     = 1'b0;
    end
  end

  // clear wins over a coincident sample, even a frame-closing one.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    valid_d = 1'b0;

    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (cnt_q == '0) begin
        acc_d = w_sample;
        cnt_d = CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        acc_d   = w_sum;
        cnt_d   = '0;
        dout_d  = w_clamped;
        sat_d   = w_sat;
        valid_d = 1'b1;
      end else begin
        acc_d = w_sum;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = dout_q;
  assign out_valid = valid_q;
  assign sat_flag  = sat_q;

endmodule

`default_nettype wire

// File: doc/accum_dump_dec.md
ACCUM_DUMP_DEC -- requirements
Module: accum_dump_dec

Interface
REQ-001 The block SHALL have parameter DW, default 25, meaning sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter DEC, default 4, meaning decimation factor, legal range 2..256.
REQ-003 The block SHALL have parameter SHIFT, default 2, meaning arithmetic right shift applied to the dump sum, legal range 0..8.
REQ-004 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 The block SHALL have port in_valid  input  1  data_in carries a sample this cycle.
REQ-007 The block SHALL have port data_in  input  DW  signed sample from the upstream delay stage.
REQ-008 The block SHALL have port clear  input  1  synchronous frame restart.
REQ-009 The block SHALL have port data_out  output  DW  signed decimated result.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle strobe qualifying data_out.
REQ-011 The block SHALL have port sat_flag  output  1  result was clamped; valid only with out_valid.

Function
REQ-012 The block SHALL hold an internal accumulator of AW = DW + ceil(log2(DEC)) bits, sign-extending every sample, so no internal overflow occurs.
REQ-013 The block SHALL hold a sample counter cnt, range 0..DEC-1, that counts accepted samples in the current frame.
REQ-014 On in_valid=1 with cnt=0, the block SHALL load acc with sext(data_in), discarding the previous frame.
REQ-015 On in_valid=1 with 0<cnt<DEC-1, the block SHALL set acc <= acc + sext(data_in) and cnt <= cnt+1.
REQ-016 On in_valid=1 with cnt=DEC-1 (frame-closing sample), the block SHALL form S = acc + sext(data_in), then set cnt <= 0.
REQ-017 On a frame-closing sample, the block SHALL register R = S >>> SHIFT (arithmetic shift, truncation toward minus infinity).
REQ-018 The block SHALL clamp R to [-2^(DW-1), 2^(DW-1)-1] into data_out and set sat_flag=1 when it clamps, else sat_flag=0.
REQ-019 The block SHALL assert out_valid for exactly one cycle, in the cycle after the clock edge that accepted the frame-closing sample (latency 1 cycle).
REQ-020 With in_valid=0, the block SHALL leave acc and cnt unchanged; gaps of any length SHALL NOT affect the result.
REQ-021 data_out and sat_flag SHALL hold their last value between strobes; out_valid SHALL be 0 in all cycles not covered by REQ-019.
REQ-022 With clear=1, at the next edge the block SHALL set cnt <= 0, acc <= 0 and out_valid <= 0, leaving data_out and sat_flag unchanged.
REQ-023 clear=1 SHALL take priority over in_valid=1 in the same cycle; that sample SHALL be dropped, including a frame-closing sample, and no strobe follows.
REQ-024 Back-to-back frames (in_valid held high) SHALL produce one out_valid strobe every DEC cycles with no lost samples.
REQ-025 A frame-closing sample and the first sample of the next frame on consecutive cycles SHALL both be accepted.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force data_out=0, out_valid=0, sat_flag=0, acc=0 and cnt=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first in_valid sample after reset release SHALL be sample 0 of a new frame.
REQ-028 After reset release, the block SHALL need no configuration before accepting samples.

Verification
REQ-029 The bench SHALL cover: DEC=4, SHIFT=2, samples 4,8,12,16 on consecutive cycles -> one cycle after sample 16, out_valid=1, data_out=10, sat_flag=0.
REQ-030 The bench SHALL cover: DEC=4, SHIFT=2, samples -1,-1,-1,-2 with two idle cycles between each -> data_out=-2 (floor of -5/4), single strobe.
REQ-031 The bench SHALL cover: DEC=4, SHIFT=0, four samples of 16777215 -> data_out=16777215, sat_flag=1; four samples of -16777216 -> data_out=-16777216, sat_flag=1.
REQ-032 The bench SHALL cover: DEC=4, samples 1,2 then clear=1 coincident with sample 3, then 4,4,4,4 -> no strobe for the first frame, next strobe data_out=4 (SHIFT=2).
REQ-033 The bench SHALL cover: reset pulsed low after two samples of 100, then 8,8,8,8 -> out_valid low during reset, subsequent data_out=8 (SHIFT=2).
REQ-034 The bench SHALL cover: in_valid held high for 12 cycles with data_in=4 -> exactly three strobes spaced 4 cycles apart, each data_out=4.
